// File: rtl/origami_pkg.sv
// origami_pkg: shared constants and types for the ORIGAMI fetch front end.
//   XLEN      address/data width
//   ILEN      instruction word width
//   INSTR_NOP canonical NOP encoding (addi x0, x0, 0)
//   PC_STEP   byte distance between sequential instructions
//   fetch_state_t  fetch FSM state: RUN (issuing) / DRAIN (discarding stale responses)
package origami_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/origami_fetch_fifo.sv
// origami_fetch_fifo: synchronous FIFO holding {pc, instr} entries between the
// instruction-memory response path and decode.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-low
//   push   in   write din (ignored when full)
//   pop    in   advance the head (ignored when empty)
//   flush  in   discard all entries; wins over push/pop
//   din    in   entry to write
//   dout   out  current head entry (registered storage, valid when !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  number of entries held
module origami_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/origami_fetch_buffer.sv
// origami_fetch_buffer: instruction-fetch front end of the ORIGAMI core.
// Issues sequential fetches over a valid/ready channel, buffers in-order
// responses and hands {pc, instr} to decode. A redirect flushes the buffer
// and discards responses still in flight.
// Build option: ORIGAMI_FETCH_BYPASS_EN -- when defined, a response arriving
// while the buffer is empty and decode is ready goes straight to decode in the
// same cycle instead of through the buffer.
// Ports:
//   clock           in   sole clock, rising edge
//   reset           in   asynchronous, active-low
//   redirect_valid  in   PC redirect from execute
//   redirect_pc     in   redirect target
//   imem_req_valid  out  fetch request
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  fetch address
//   imem_resp_valid in   response, one per accepted request, in order
//   imem_resp_data  in   instruction word
//   id_valid        out  decode entry valid
//   id_ready        in   decode accepts entry
//   id_pc           out  PC of presented instruction
//   id_instr        out  presented instruction
module origami_fetch_buffer import origami_pkg::*; #(
    parameter int unsigned        XLEN     = origami_pkg::XLEN,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_n;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            req_fire;
    logic            resp_take;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;

    // Buffer occupancy plus outstanding requests never exceeds DEPTH, so every
    // response is guaranteed a slot.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req_valid = reset && (state == RUN) && !redirect_valid && !fifo_full
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_take      = imem_resp_valid && (drop_cnt == '0);

`ifdef ORIGAMI_FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = reset && resp_take && fifo_empty && id_ready && !redirect_valid;
    assign id_valid  = !fifo_empty || bypass;
    assign id_pc     = bypass ? resp_pc : head_pc;
    assign id_instr  = bypass ? imem_resp_data : head_instr;
    assign fifo_push = resp_take && !redirect_valid && !bypass;
`else
    assign id_valid  = !fifo_empty;
    assign id_pc     = head_pc;
    assign id_instr  = head_instr;
    assign fifo_push = resp_take && !redirect_valid;
`endif

    // Popping under redirect is harmless: flush wins inside the FIFO, and the
    // presented entry still counts as consumed by decode.
    assign fifo_pop = id_ready && !fifo_empty;

    origami_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   ({resp_pc, imem_resp_data}),
        .dout  ({head_pc, head_instr}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // On redirect every outstanding request becomes stale, except one whose
    // response is arriving this very cycle (it is discarded right here).
    always_comb begin
        state_n = state;
        drop_n  = drop_cnt;
        if (redirect_valid) begin
            drop_n = inflight - (imem_resp_valid ? CW'(1) : CW'(0));
        end else if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_n = drop_cnt - CW'(1);
        end
        case (state)
            RUN:     if (drop_n != '0) state_n = DRAIN;
            DRAIN:   if (drop_n == '0) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            drop_cnt <= drop_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                if (resp_take) resp_pc  <= resp_pc + XLEN'(PC_STEP);
            end
            // No request can fire during a redirect, so this covers both cases.
            case ({req_fire, imem_resp_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_origami_fetch_buffer.sv
// Self-checking bench for origami_fetch_buffer. A behavioural instruction
// memory with configurable latency answers requests in order; every
// non-stale response becomes an expected decode entry in a scoreboard queue
// that is compared against each decode handshake.
module tb_origami_fetch_buffer;
    import origami_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    origami_fetch_buffer #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t pend[$];
    exp_t  expq[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          rdy = 1'b1;
    bit          idr = 1'b1;
    bit          redir = 1'b0;
    logic [31:0] redir_pc = '0;
    bit          rel = 1'b0;
    bit          id_fired = 1'b0;
    bit          resp_drv = 1'b0;
    int          exp_drop = 0;
    bit          cap_req = 1'b0;
    bit          cap_done = 1'b0;
    logic [31:0] cap_addr = '1;
    bit          cap_id = 1'b0;
    bit          cap_id_done = 1'b0;
    logic [31:0] cap_id_pc = '1;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h0013};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample 1 time unit
    // later, and account for what the next rising edge will commit.
    task automatic step();
        pend_t p;
        exp_t  e;
        @(negedge clock);
        if (rel) reset = 1'b1;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        resp_drv        = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_drv        = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = memw(pend[0].addr);
        end
        #1;
        if (rel) begin
            check("rel_req_valid", 64'(imem_req_valid), 64'd1);
            check("rel_req_addr", 64'(imem_req_addr), 64'h0);
            rel = 1'b0;
        end
        if (resp_drv) begin
            p = pend.pop_front();
            if (!p.stale && !redir) begin
                e.pc    = p.addr;
                e.instr = memw(p.addr);
                expq.push_back(e);
            end
        end
        id_fired = id_valid && id_ready;
        if (id_fired) begin
            if (expq.size() == 0) begin
                check("sb_extra_entry", 64'(expq.size()), 64'd1);
            end else begin
                e = expq.pop_front();
                check("sb_pc", 64'(id_pc), 64'(e.pc));
                check("sb_instr", 64'(id_instr), 64'(e.instr));
            end
            if (cap_id && !cap_id_done) begin
                cap_id_pc   = id_pc;
                cap_id_done = 1'b1;
            end
        end
        if (redir) begin
            expq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_drop = pend.size();
        end
        if (imem_req_valid && imem_req_ready) begin
            p.addr  = imem_req_addr;
            p.due   = cyc + lat;
            p.stale = 1'b0;
            pend.push_back(p);
            if (cap_req && !cap_done) begin
                cap_addr = imem_req_addr;
                cap_done = 1'b1;
            end
        end
        cyc++;
    endtask

    // Asserts reset mid-cycle and checks outputs clear at once; the following
    // step() releases it.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", 64'(imem_req_addr), 64'h0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_pc", 64'(id_pc), 64'h0);
        check("rst_id_instr", 64'(id_instr), 64'h0);
        pend.delete();
        expq.delete();
        rel = 1'b1;
    endtask

    task automatic wait_first_id();
        cap_id_done = 1'b0;
        cap_id_pc   = '1;
        cap_id      = 1'b1;
        for (int i = 0; i < 30 && !cap_id_done; i++) step();
        cap_id = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming: always-ready memory, latency 1, decode always ready.
        lat = 1; rdy = 1'b1; idr = 1'b1;
        apply_reset();
        step(); step(); step();
        for (int i = 0; i < 12; i++) begin
            step();
            check("t2_stream", 64'(id_fired), 64'd1);
        end

        // Reset mid-stream, then bypass/latency on an empty buffer.
        apply_reset();
        step();
        step();
`ifdef ORIGAMI_FETCH_BYPASS_EN
        check("t6_same_cycle", 64'(id_valid), 64'd1);
`else
        check("t6_same_cycle", 64'(id_valid), 64'd0);
        step();
        check("t6_next_cycle", 64'(id_valid), 64'd1);
`endif
        check("t6_pc", 64'(id_pc), 64'h0);
        for (int i = 0; i < 6; i++) step();

        // Decode stalled: buffer fills to DEPTH and issue stops.
        idr = 1'b0;
        apply_reset();
        for (int i = 0; i < 9; i++) step();
        check("t3_req_stall", 64'(imem_req_valid), 64'd0);
        check("t3_count", 64'(dut.fifo_count), 64'd4);
        check("t3_id_valid", 64'(id_valid), 64'd1);
        check("t3_head_pc", 64'(id_pc), 64'h0);
        cap_done = 1'b0; cap_addr = '1; cap_req = 1'b1;
        idr = 1'b1;
        for (int i = 0; i < 20 && !cap_done; i++) step();
        cap_req = 1'b0;
        check("t3_resume_addr", 64'(cap_addr), 64'h10);
        for (int i = 0; i < 10; i++) step();

        // Redirect with two requests in flight.
        lat = 3;
        apply_reset();
        step(); step();
        redir = 1'b1; redir_pc = 32'h100;
        step();
        redir = 1'b0;
        step();
        check("t4_drop_cnt", 64'(dut.drop_cnt), 64'(exp_drop));
        check("t4_state", 64'(dut.state), 64'(DRAIN));
        wait_first_id();
        check("t4_first_pc", 64'(cap_id_pc), 64'h100);
        for (int i = 0; i < 8; i++) step();

        // Redirect coinciding with a response and a pop.
        lat = 2;
        apply_reset();
        for (int i = 0; i < 7; i++) step();
        redir = 1'b1; redir_pc = 32'h200;
        step();
        redir = 1'b0;
        check("t5_resp_same_cycle", 64'(resp_drv), 64'd1);
`ifndef ORIGAMI_FETCH_BYPASS_EN
        check("t5_pop_same_cycle", 64'(id_fired), 64'd1);
`endif
        step();
        check("t5_drop_cnt", 64'(dut.drop_cnt), 64'(exp_drop));
        check("t5_empty", 64'(id_valid), 64'd0);
        wait_first_id();
        check("t5_first_pc", 64'(cap_id_pc), 64'h200);
        for (int i = 0; i < 8; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
